konami_watchdog_gen2: RTL and testbench
=======================================

Name: konami_watchdog_gen2

Overview:
- Parametrised successor to the custom-chip frame watchdog.
- Counts vertical-blank entries. The count is cleared only when every enabled CPU/subsystem channel has kicked since the last clear.
- On overflow it asserts a board reset pulse of programmable width, followed by a programmable grace period.
- Sits beside the video timing divider. Drives the system reset tree and the diagnostic status bits.

Parameters:
- NCHAN, 2, number of independent kick channels.
- LIMIT, 8, vblank entries without a full kick set before a bite (≥1).
- PULSE_CYCLES, 16, clk cycles the reset output is held (≥1).
- GRACE_FRAMES, 2, vblank entries ignored after a bite before counting resumes (0 = none).
- CNT_W, $clog2(LIMIT+1), width of frame_cnt_o (derived, do not override).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nReset  input  1  asynchronous active-low reset.
- en_i  input  1  watchdog enable.
- vblank_n_i  input  1  active-low VBLANK, already synchronous to clk.
- kick_i  input  NCHAN  per-channel kick strobes, 1-cycle or level.
- kick_mask_i  input  NCHAN  1 = channel participates.
- wdog_rst_o  output  1  active-high reset pulse.
- wdog_rst_n_o  output  1  inverse of wdog_rst_o.
- frame_cnt_o  output  CNT_W  current frame count.
- warn_o  output  1  frame_cnt_o == LIMIT-1 in RUN.
- bite_cnt_o  output  8  bites since reset, saturates at 255.
- state_o  output  2  IDLE=0, RUN=1, BITE=2, GRACE=3.

Behaviour:
- Reset (nReset low, asynchronous): state IDLE, frame_cnt 0, kick_seen 0, pulse/grace counters 0, vblank_n_q 1, bite_cnt 0, wdog_rst_o 0, wdog_rst_n_o 1, warn_o 0.
- Edge detect: fall = vblank_n_q & ~vblank_n_i. vblank_n_q <= vblank_n_i every cycle.
- Kick tracking: kick_seen[i] is sticky; set when kick_i[i] & kick_mask_i[i].
  - all_kicked = &(kick_seen | kick_i | ~kick_mask_i), evaluated on the current cycle's kick_i.
  - All-zero mask gives all_kicked = 1 permanently, so the count never advances.
- IDLE: frame_cnt and kick_seen held at 0. en_i=1 → RUN next edge.
- RUN:
  - en_i=0 → IDLE; frame_cnt and kick_seen cleared.
  - all_kicked → frame_cnt <= 0, kick_seen <= 0. Clear wins over a simultaneous fall.
  - Otherwise, on fall: frame_cnt <= frame_cnt+1.
  - If the incremented value == LIMIT, the same edge sets state BITE, wdog_rst_o 1, pulse counter 0, bite_cnt +1 (saturating). frame_cnt holds LIMIT.
- BITE:
  - wdog_rst_o high for exactly PULSE_CYCLES consecutive cycles, counted from the edge of entry.
  - Kicks, fall and en_i are all ignored; the pulse is never truncated.
  - On the final cycle: wdog_rst_o <= 0; frame_cnt <= 0; kick_seen <= 0; grace counter <= 0.
  - Next state: GRACE if GRACE_FRAMES>0, else RUN. If en_i=0 at that point, go to IDLE instead.
- GRACE:
  - kick_seen held 0, frame_cnt held 0.
  - Each fall increments the grace counter. Reaching GRACE_FRAMES → RUN on the same edge.
  - en_i=0 → IDLE.
- warn_o, wdog_rst_n_o, state_o and frame_cnt_o are registered or direct decodes of registered state; no combinational path from inputs.
- Mid-operation nReset: immediate return to reset values, including mid-pulse (wdog_rst_o drops asynchronously).
- Kicks on masked channels never set kick_seen. Changing kick_mask_i takes effect on the next cycle's all_kicked.

Test Plan:
- Defaults, mask=2'b11, en_i=1, no kicks, 8 vblank falls → frame_cnt_o 1..8; warn_o high after 7th fall; wdog_rst_o high 16 cycles starting the 8th-fall edge; bite_cnt_o=1; state 2→3.
- Defaults, kick ch0 each frame, ch1 only every 3rd frame → frame_cnt_o never exceeds 3, no bite. Kick ch0 only → bite after 8 falls.
- Fall and the completing kick on the same cycle with frame_cnt=7 → frame_cnt_o=0, no bite.
- GRACE_FRAMES=2 after a bite: kicks withheld, 2 falls → state RUN with frame_cnt_o=0; the 3rd fall → frame_cnt_o=1.
- en_i dropped at cycle 5 of a BITE → wdog_rst_o still 16 cycles total, then state_o=0. nReset low at cycle 5 → wdog_rst_o=0 immediately, all outputs at reset values.
- mask=2'b00, 300 falls → no bite, frame_cnt_o stays 0. Force 256 bites (LIMIT=1, PULSE_CYCLES=1, GRACE_FRAMES=0) → bite_cnt_o saturates at 255.

Source files
------------

// File: rtl/konami_watchdog_gen2.sv
// konami_watchdog_gen2
//
// Frame watchdog. Counts vertical-blank entries (falling edges of vblank_n_i).
// The count is cleared only when every enabled kick channel has kicked since
// the last clear. If LIMIT frames pass without a full kick set, the block
// "bites": it drives a board reset pulse PULSE_CYCLES clocks wide. It then
// ignores GRACE_FRAMES vblank entries before it starts counting again.
//
// Ports
//   clk           system clock, rising edge
//   nReset        asynchronous active-low reset
//   en_i          watchdog enable
//   vblank_n_i    active-low VBLANK, synchronous to clk
//   kick_i        per-channel kick strobes (pulse or level)
//   kick_mask_i   1 = channel participates in the kick set
//   wdog_rst_o    active-high board reset pulse
//   wdog_rst_n_o  inverse of wdog_rst_o
//   frame_cnt_o   current frame count
//   warn_o        one frame left before a bite (RUN only)
//   bite_cnt_o    bites since reset, saturating at 255
//   state_o       IDLE=0, RUN=1, BITE=2, GRACE=3
//
// state | meaning
// IDLE  | disabled; frame count and kick record held at zero
// RUN   | counting vblank entries, collecting kicks
// BITE  | reset pulse active; all inputs ignored until the pulse completes
// GRACE | ignoring vblank entries after a bite; kicks are not recorded
module konami_watchdog_gen2 #(
    parameter int NCHAN        = 2,
    parameter int LIMIT        = 8,
    parameter int PULSE_CYCLES = 16,
    parameter int GRACE_FRAMES = 2,
    parameter int CNT_W        = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             en_i,
    input  logic             vblank_n_i,
    input  logic [NCHAN-1:0] kick_i,
    input  logic [NCHAN-1:0] kick_mask_i,
    output logic             wdog_rst_o,
    output logic             wdog_rst_n_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             warn_o,
    output logic [7:0]       bite_cnt_o,
    output logic [1:0]       state_o
);

    // Pulse and grace timers are down-counters loaded with (length - 1);
    // the terminal count of zero marks the final cycle / final frame.
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BITE  = 2'd2,
        ST_GRACE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [NCHAN-1:0] kick_seen;
    logic [PW-1:0]    pulse_cnt;
    logic [GW-1:0]    grace_cnt;
    logic             vblank_n_q;
    logic [7:0]       bite_cnt;
    logic             wdog_rst;

    logic             fall;
    logic             all_kicked;
    logic [NCHAN-1:0] kick_hit;
    logic [CNT_W-1:0] frame_inc;

    assign fall      = vblank_n_q & ~vblank_n_i;
    assign kick_hit  = kick_i & kick_mask_i;
    // Masked channels count as kicked, so an all-zero mask is always satisfied.
    assign all_kicked = &(kick_seen | kick_i | ~kick_mask_i);
    // frame_cnt is below LIMIT whenever this is used, so it cannot wrap.
    assign frame_inc = frame_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            kick_seen  <= '0;
            pulse_cnt  <= '0;
            grace_cnt  <= '0;
            vblank_n_q <= 1'b1;
            bite_cnt   <= '0;
            wdog_rst   <= 1'b0;
        end else begin
            vblank_n_q <= vblank_n_i;
            case (state)
                ST_IDLE: begin
                    frame_cnt <= '0;
                    kick_seen <= '0;
                    if (en_i) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state     <= ST_IDLE;
                        frame_cnt <= '0;
                        kick_seen <= '0;
                    end else if (all_kicked) begin
                        // A completed kick set wins over a coincident vblank entry.
                        frame_cnt <= '0;
                        kick_seen <= '0;
                    end else begin
                        kick_seen <= kick_seen | kick_hit;
                        if (fall) begin
                            frame_cnt <= frame_inc;
                            if (frame_inc == CNT_W'(LIMIT)) begin
                                state     <= ST_BITE;
                                wdog_rst  <= 1'b1;
                                pulse_cnt <= PW'(PULSE_CYCLES - 1);
                                if (bite_cnt != 8'hFF) begin
                                    bite_cnt <= bite_cnt + 8'd1;
                                end
                            end
                        end
                    end
                end
                ST_BITE: begin
                    // The pulse always runs to full width, even if en_i drops.
                    if (pulse_cnt == '0) begin
                        wdog_rst  <= 1'b0;
                        frame_cnt <= '0;
                        kick_seen <= '0;
                        grace_cnt <= GW'((GRACE_FRAMES > 0) ? GRACE_FRAMES - 1 : 0);
                        if (!en_i) begin
                            state <= ST_IDLE;
                        end else if (GRACE_FRAMES > 0) begin
                            state <= ST_GRACE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                    end
                end
                ST_GRACE: begin
                    frame_cnt <= '0;
                    kick_seen <= '0;
                    if (!en_i) begin
                        state <= ST_IDLE;
                    end else if (fall) begin
                        if (grace_cnt == '0) begin
                            state <= ST_RUN;
                        end else begin
                            grace_cnt <= grace_cnt - GW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wdog_rst_o   = wdog_rst;
    assign wdog_rst_n_o = ~wdog_rst;
    assign frame_cnt_o  = frame_cnt;
    assign warn_o       = (state == ST_RUN) && (frame_cnt == CNT_W'(LIMIT - 1));
    assign bite_cnt_o   = bite_cnt;
    assign state_o      = state;

endmodule

// File: tb/tb_konami_watchdog_gen2.sv
// Testbench for konami_watchdog_gen2.
// dut0 uses the default parameters and is compared every cycle against a
// behavioural model; dut1 (LIMIT=1, PULSE_CYCLES=1, GRACE_FRAMES=0) is used
// for the bite counter saturation scenario.
module tb_konami_watchdog_gen2;

    localparam int L = 8;
    localparam int P = 16;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       nReset;
    logic       en, vblank_n;
    logic [1:0] kick, mask;
    logic       wdog_rst, wdog_rst_n, warn;
    logic [3:0] frame_cnt;
    logic [7:0] bite_cnt;
    logic [1:0] state;

    logic       en1, vb1;
    logic [1:0] kick1, mask1;
    logic       rst1, rstn1, warn1;
    logic       frame1;
    logic [7:0] bite1;
    logic [1:0] state1;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state (dut0)
    int         m_mode, m_frames, m_pulse_left, m_grace, m_bites;
    logic [1:0] m_seen;
    logic       m_prev_vb;

    always #5 clk = ~clk;

    konami_watchdog_gen2 dut0 (
        .clk(clk), .nReset(nReset), .en_i(en), .vblank_n_i(vblank_n),
        .kick_i(kick), .kick_mask_i(mask),
        .wdog_rst_o(wdog_rst), .wdog_rst_n_o(wdog_rst_n), .frame_cnt_o(frame_cnt),
        .warn_o(warn), .bite_cnt_o(bite_cnt), .state_o(state)
    );

    konami_watchdog_gen2 #(.LIMIT(1), .PULSE_CYCLES(1), .GRACE_FRAMES(0)) dut1 (
        .clk(clk), .nReset(nReset), .en_i(en1), .vblank_n_i(vb1),
        .kick_i(kick1), .kick_mask_i(mask1),
        .wdog_rst_o(rst1), .wdog_rst_n_o(rstn1), .frame_cnt_o(frame1),
        .warn_o(warn1), .bite_cnt_o(bite1), .state_o(state1)
    );

    task automatic model_reset();
        m_mode = 0; m_frames = 0; m_pulse_left = 0; m_grace = 0; m_bites = 0;
        m_seen = 2'b00; m_prev_vb = 1'b1;
    endtask

    // One clock of the watchdog rules, applied to the inputs present at the edge.
    task automatic model_step();
        logic f;
        f = m_prev_vb && !vblank_n;
        m_prev_vb = vblank_n;
        case (m_mode)
            0: begin
                m_frames = 0; m_seen = 2'b00;
                if (en) m_mode = 1;
            end
            1: begin
                if (!en) begin
                    m_mode = 0; m_frames = 0; m_seen = 2'b00;
                end else if ((m_seen | kick | ~mask) == 2'b11) begin
                    m_frames = 0; m_seen = 2'b00;
                end else begin
                    m_seen = m_seen | (kick & mask);
                    if (f) begin
                        m_frames++;
                        if (m_frames == L) begin
                            m_mode = 2;
                            m_pulse_left = P;
                            if (m_bites < 255) m_bites++;
                        end
                    end
                end
            end
            2: begin
                m_pulse_left--;
                if (m_pulse_left == 0) begin
                    m_frames = 0; m_seen = 2'b00; m_grace = 0;
                    m_mode = !en ? 0 : (G > 0 ? 3 : 1);
                end
            end
            default: begin
                m_frames = 0; m_seen = 2'b00;
                if (!en) m_mode = 0;
                else if (f) begin
                    m_grace++;
                    if (m_grace == G) m_mode = 1;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (nReset) model_step();
        @(negedge clk);
    endtask

    function automatic logic [16:0] dut_vec();
        return {state, frame_cnt, warn, wdog_rst, wdog_rst_n, bite_cnt};
    endfunction

    function automatic logic [16:0] exp_vec();
        logic b;
        logic w;
        b = (m_mode == 2);
        w = (m_mode == 1) && (m_frames == L - 1);
        return {2'(m_mode), 4'(m_frames), w, b, ~b, 8'(m_bites)};
    endfunction

    task automatic do_reset();
        nReset = 1'b0;
        en = 1'b0; vblank_n = 1'b1; kick = 2'b00; mask = 2'b11;
        model_reset();
        tick();
        tick();
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        en1 = 1'b0; vb1 = 1'b1; kick1 = 2'b00; mask1 = 2'b11;
        do_reset();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
        vectors++; if (frame_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_frame: got %0d want 0", frame_cnt); end
        vectors++; if (wdog_rst !== 1'b0 || wdog_rst_n !== 1'b1) begin miscompares++; $display("FAIL reset_rst: got %b/%b want 0/1", wdog_rst, wdog_rst_n); end
        vectors++; if (warn !== 1'b0) begin miscompares++; $display("FAIL reset_warn: got %b want 0", warn); end
        vectors++; if (bite_cnt !== 8'd0 || bite1 !== 8'd0) begin miscompares++; $display("FAIL reset_bite: got %0d/%0d want 0/0", bite_cnt, bite1); end
        vectors++; if (state1 !== 2'd0) begin miscompares++; $display("FAIL reset_state1: got %0d want 0", state1); end
    endtask

    // No kicks: 8 falls bite; then the grace window swallows two falls.
    task automatic test_bite_and_grace();
        int hi;
        en = 1'b1; kick = 2'b00;
        tick();
        vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL bite_run: got %h want %h", dut_vec(), exp_vec()); end
        for (int f = 0; f < 8; f++) begin
            vblank_n = 1'b0;
            tick();
            vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL bite_fall%0d: got %h want %h", f, dut_vec(), exp_vec()); end
            vectors++; if (frame_cnt !== 4'(f + 1)) begin miscompares++; $display("FAIL bite_frame%0d: got %0d want %0d", f, frame_cnt, f + 1); end
            if (f == 6) begin
                vectors++; if (warn !== 1'b1) begin miscompares++; $display("FAIL bite_warn: got %b want 1", warn); end
            end
            if (f < 7) begin
                vblank_n = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL bite_gap: got %h want %h", dut_vec(), exp_vec()); end
                end
            end
        end
        vblank_n = 1'b1;
        hi = 0;
        for (int g = 0; g < 40 && wdog_rst === 1'b1; g++) begin
            hi++;
            tick();
            vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL bite_pulse: got %h want %h", dut_vec(), exp_vec()); end
        end
        vectors++; if (hi !== 16) begin miscompares++; $display("FAIL bite_width: got %0d want 16", hi); end
        vectors++; if (state !== 2'd3 || bite_cnt !== 8'd1) begin miscompares++; $display("FAIL bite_after: got st=%0d bites=%0d want 3/1", state, bite_cnt); end
        for (int g = 0; g < 3; g++) begin
            vblank_n = 1'b0;
            tick();
            vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL grace_fall%0d: got %h want %h", g, dut_vec(), exp_vec()); end
            if (g == 1) begin
                vectors++; if (state !== 2'd1 || frame_cnt !== 4'd0) begin miscompares++; $display("FAIL grace_end: got st=%0d fc=%0d want 1/0", state, frame_cnt); end
            end
            if (g == 2) begin
                vectors++; if (frame_cnt !== 4'd1) begin miscompares++; $display("FAIL grace_resume: got %0d want 1", frame_cnt); end
            end
            vblank_n = 1'b1;
            tick();
            tick();
        end
    endtask

    // ch0 kicks every frame, ch1 every third: count stays low; then ch0 only.
    task automatic test_partial_kick();
        int maxf, len, k0, k1;
        do_reset();
        en = 1'b1;
        tick();
        maxf = 0;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(3, 6);
            k0 = $urandom_range(1, len - 1);
            k1 = (f < 12 && f % 3 == 2) ? $urandom_range(1, len - 1) : -1;
            for (int c = 0; c < len; c++) begin
                vblank_n = (c != 0);
                kick = {c == k1, c == k0};
                tick();
                vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL partial_f%0d_c%0d: got %h want %h", f, c, dut_vec(), exp_vec()); end
                if (f < 12 && int'(frame_cnt) > maxf) maxf = frame_cnt;
                if (f == 19 && c == 0) begin
                    vectors++; if (state !== 2'd2 || bite_cnt !== 8'd1) begin miscompares++; $display("FAIL partial_ch0_bite: got st=%0d bites=%0d want 2/1", state, bite_cnt); end
                end
            end
            if (f == 11) begin
                vectors++; if (maxf > 3 || bite_cnt !== 8'd0) begin miscompares++; $display("FAIL partial_max: got max=%0d bites=%0d want <=3/0", maxf, bite_cnt); end
            end
        end
        kick = 2'b00;
        vblank_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL partial_drain: got %h want %h", dut_vec(), exp_vec()); end
        end
    endtask

    // Fall coincides with the kick that completes the set at frame_cnt=7.
    task automatic test_same_cycle();
        do_reset();
        en = 1'b1;
        tick();
        for (int f = 0; f < 7; f++) begin
            vblank_n = 1'b0;
            tick();
            vblank_n = 1'b1;
            tick();
            tick();
        end
        vectors++; if (frame_cnt !== 4'd7 || warn !== 1'b1) begin miscompares++; $display("FAIL same_pre: got fc=%0d warn=%b want 7/1", frame_cnt, warn); end
        kick = 2'b01;
        tick();
        kick = 2'b00;
        tick();
        vblank_n = 1'b0;
        kick = 2'b10;
        tick();
        kick = 2'b00;
        vblank_n = 1'b1;
        vectors++; if (frame_cnt !== 4'd0 || state !== 2'd1 || wdog_rst !== 1'b0 || bite_cnt !== 8'd0) begin
            miscompares++; $display("FAIL same_cycle: got fc=%0d st=%0d rst=%b bites=%0d want 0/1/0/0", frame_cnt, state, wdog_rst, bite_cnt);
        end
        vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL same_model: got %h want %h", dut_vec(), exp_vec()); end
    endtask

    task automatic reach_bite();
        do_reset();
        en = 1'b1;
        tick();
        for (int f = 0; f < 8; f++) begin
            vblank_n = 1'b0;
            tick();
            vblank_n = 1'b1;
            if (f < 7) begin
                tick();
                tick();
            end
        end
    endtask

    task automatic test_en_drop_in_bite();
        int hi;
        reach_bite();
        hi = 0;
        for (int g = 0; g < 40 && wdog_rst === 1'b1; g++) begin
            hi++;
            if (hi == 5) en = 1'b0;
            kick = 2'($urandom_range(0, 3));
            vblank_n = 1'($urandom_range(0, 1));
            tick();
            vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL endrop_cyc%0d: got %h want %h", hi, dut_vec(), exp_vec()); end
        end
        kick = 2'b00;
        vectors++; if (hi !== 16) begin miscompares++; $display("FAIL endrop_width: got %0d want 16", hi); end
        vectors++; if (state !== 2'd0 || frame_cnt !== 4'd0) begin miscompares++; $display("FAIL endrop_idle: got st=%0d fc=%0d want 0/0", state, frame_cnt); end
    endtask

    task automatic test_reset_mid_bite();
        reach_bite();
        for (int c = 0; c < 4; c++) tick();
        vectors++; if (wdog_rst !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: got %b want 1", wdog_rst); end
        nReset = 1'b0;
        #1;
        vectors++; if (wdog_rst !== 1'b0 || wdog_rst_n !== 1'b1) begin miscompares++; $display("FAIL midrst_rst: got %b/%b want 0/1", wdog_rst, wdog_rst_n); end
        vectors++; if (state !== 2'd0 || frame_cnt !== 4'd0 || warn !== 1'b0 || bite_cnt !== 8'd0) begin
            miscompares++; $display("FAIL midrst_outs: got st=%0d fc=%0d warn=%b bites=%0d want 0/0/0/0", state, frame_cnt, warn, bite_cnt);
        end
        model_reset();
        en = 1'b0; vblank_n = 1'b1;
        tick();
        nReset = 1'b1;
    endtask

    task automatic test_mask_zero();
        int maxf;
        int rst_seen;
        do_reset();
        mask = 2'b00;
        en = 1'b1;
        tick();
        maxf = 0;
        rst_seen = 0;
        for (int f = 0; f < 300; f++) begin
            for (int c = 0; c < 2; c++) begin
                vblank_n = (c != 0);
                kick = 2'($urandom_range(0, 3));
                tick();
                vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL mask0_f%0d: got %h want %h", f, dut_vec(), exp_vec()); end
                if (int'(frame_cnt) > maxf) maxf = frame_cnt;
                if (wdog_rst !== 1'b0) rst_seen++;
            end
        end
        vectors++; if (maxf != 0 || rst_seen != 0 || bite_cnt !== 8'd0) begin
            miscompares++; $display("FAIL mask0: got max=%0d rst=%0d bites=%0d want 0/0/0", maxf, rst_seen, bite_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mask = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 63) != 0);
            kick = {($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0)};
            vblank_n = ($urandom_range(0, 3) != 0);
            tick();
            vectors++; if (dut_vec() !== exp_vec()) begin miscompares++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec()); end
        end
        en = 1'b0; kick = 2'b00; vblank_n = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        int pulses;
        en1 = 1'b1; mask1 = 2'b11; kick1 = 2'b00; vb1 = 1'b1;
        tick();
        vectors++; if (state1 !== 2'd1 || warn1 !== 1'b1) begin miscompares++; $display("FAIL sat_warn: got st=%0d warn=%b want 1/1", state1, warn1); end
        pulses = 0;
        for (int i = 1; i <= 300; i++) begin
            vb1 = 1'b0;
            tick();
            if (rst1 === 1'b1 && rstn1 === 1'b0) pulses++;
            vb1 = 1'b1;
            tick();
            if (i == 10 || i == 255 || i == 256 || i == 300) begin
                vectors++; if (bite1 !== 8'((i > 255) ? 255 : i)) begin
                    miscompares++; $display("FAIL sat_bites%0d: got %0d want %0d", i, bite1, (i > 255) ? 255 : i);
                end
            end
        end
        vectors++; if (pulses != 300 || rst1 !== 1'b0 || state1 !== 2'd1) begin
            miscompares++; $display("FAIL sat_pulses: got %0d rst=%b st=%0d want 300/0/1", pulses, rst1, state1);
        end
    endtask

    initial begin
        nReset = 1'b0;
        en = 1'b0; vblank_n = 1'b1; kick = 2'b00; mask = 2'b11;
        en1 = 1'b0; vb1 = 1'b1; kick1 = 2'b00; mask1 = 2'b11;
        model_reset();
        @(negedge clk);
        test_reset();
        test_bite_and_grace();
        test_partial_kick();
        test_same_cycle();
        test_en_drop_in_bite();
        test_reset_mid_bite();
        test_mask_zero();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
